// File: rtl/vram_pkg.sv
// Shared VRAM geometry and the fill-sequencer state encoding.
package vram_pkg;
   localparam int VRAM_AW = 11;
   localparam int VRAM_DW = 16;

   typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;
endpackage

// File: rtl/vram_fill_seq.sv
// Whole-VRAM fill engine: walks every address once, writing only on cycles it is granted.
module vram_fill_seq
   import vram_pkg::*;
#(
   parameter int AW = VRAM_AW,
   parameter int DW = VRAM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic [DW-1:0] value_i,
   input  logic          grant_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] wdata_o
);

   fill_state_e   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] value_q, value_d;
   logic          done_q, done_d;

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      done_d  = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            if (start_i) begin
               state_d = FILL_RUN;
               cnt_d   = '0;
               value_d = value_i;
            end
         end
         FILL_RUN: begin
            // A start while running is deliberately ignored; the latched value stays.
            if (grant_i) begin
               cnt_d = cnt_q + AW'(1);
               if (cnt_q == {AW{1'b1}}) begin
                  state_d = FILL_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use <= so every flop samples the same pre-edge values.
      if (reset) begin
         state_q <= FILL_IDLE;
         cnt_q   <= '0;
         value_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (state_q == FILL_RUN);
   assign done_o  = done_q;
   assign addr_o  = cnt_q;
   assign wdata_o = value_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch > buffered CPU access > background fill.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int AW = VRAM_AW,
   parameter int DW = VRAM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic [DW-1:0] disp_rdata,
   input  logic          cpu_req,
   output logic          cpu_rdy,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   input  logic          fill_start,
   input  logic [DW-1:0] fill_value,
   output logic          fill_busy,
   output logic          fill_done,
   output logic [AW-1:0] sram_addr,
   output logic          sram_we,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata
);

   logic          pend_valid_q, pend_valid_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic          pend_we_q, pend_we_d;
   logic [DW-1:0] pend_wdata_q, pend_wdata_d;
   logic          cpu_done_q, cpu_done_d;

   logic          cpu_accept;
   logic          cpu_issue;
   logic          fill_grant;
   logic [AW-1:0] fill_addr;
   logic [DW-1:0] fill_wdata;

   assign cpu_rdy    = !pend_valid_q;
   assign cpu_accept = cpu_req && cpu_rdy;
   // Writes are masked during reset so an aborted fill or dropped request never lands.
   assign cpu_issue  = pend_valid_q && !disp_req && !reset;
   assign fill_grant = fill_busy && !disp_req && !pend_valid_q && !reset;

   vram_fill_seq #(.AW(AW), .DW(DW)) u_fill (
      .clk     (clk),
      .reset   (reset),
      .start_i (fill_start),
      .value_i (fill_value),
      .grant_i (fill_grant),
      .busy_o  (fill_busy),
      .done_o  (fill_done),
      .addr_o  (fill_addr),
      .wdata_o (fill_wdata)
   );

   // Combinational grant keeps the display's address-to-data latency at one cycle.
   always_comb begin
      sram_addr  = '0;
      sram_we    = 1'b0;
      sram_wdata = '0;
      if (disp_req) begin
         sram_addr = disp_addr;
      end else if (cpu_issue) begin
         sram_addr  = pend_addr_q;
         sram_we    = pend_we_q;
         sram_wdata = pend_wdata_q;
      end else if (fill_grant) begin
         sram_addr  = fill_addr;
         sram_we    = 1'b1;
         sram_wdata = fill_wdata;
      end
   end

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_we_d    = pend_we_q;
      pend_wdata_d = pend_wdata_q;
      cpu_done_d   = cpu_issue;
      if (cpu_issue) pend_valid_d = 1'b0;
      if (cpu_accept) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = cpu_addr;
         pend_we_d    = cpu_we;
         pend_wdata_d = cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_we_q    <= 1'b0;
         pend_wdata_q <= '0;
         cpu_done_q   <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_we_q    <= pend_we_d;
         pend_wdata_q <= pend_wdata_d;
         cpu_done_q   <= cpu_done_d;
      end
   end

   assign cpu_done   = cpu_done_q;
   assign cpu_rdata  = sram_rdata;
   assign disp_rdata = sram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scenario bench for vram_arbiter with a behavioural synchronous-read VRAM.
module tb_vram_arbiter;

   logic        clk;
   logic        reset;
   logic        disp_req;
   logic [10:0] disp_addr;
   logic [15:0] disp_rdata;
   logic        cpu_req;
   logic        cpu_rdy;
   logic        cpu_we;
   logic [10:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_done;
   logic [15:0] cpu_rdata;
   logic        fill_start;
   logic [15:0] fill_value;
   logic        fill_busy;
   logic        fill_done;
   logic [10:0] sram_addr;
   logic        sram_we;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;

   vram_arbiter #(.AW(11), .DW(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_rdata (disp_rdata),
      .cpu_req    (cpu_req),
      .cpu_rdy    (cpu_rdy),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_done   (cpu_done),
      .cpu_rdata  (cpu_rdata),
      .fill_start (fill_start),
      .fill_value (fill_value),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .sram_addr  (sram_addr),
      .sram_we    (sram_we),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural VRAM with bench-side bulk init and single-word poke.
   logic [15:0] mem [0:2047];
   logic        init_en;
   logic [15:0] init_base;
   logic        poke_en;
   logic [10:0] poke_addr;
   logic [15:0] poke_data;

   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 2048; i++) mem[i] <= init_base ^ 16'(i);
      end else begin
         if (poke_en) mem[poke_addr] <= poke_data;
         if (sram_we) mem[sram_addr] <= sram_wdata;
      end
      sram_rdata <= mem[sram_addr];
   end

   typedef struct packed {
      logic        we;
      logic [15:0] data;
   } cpu_exp_t;

   cpu_exp_t    cpu_q [$];
   logic [15:0] disp_q [$];
   int          wcnt [2048];
   int          checks;
   int          errors;

   function automatic logic [15:0] bg(input int a);
      return 16'hC000 ^ 16'(a);
   endfunction

   task automatic next();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic init_mem(input logic [15:0] base);
      next(); init_en = 1'b1; init_base = base; settle();
      next(); init_en = 1'b0; settle();
   endtask

   task automatic poke(input logic [10:0] a, input logic [15:0] d);
      next(); poke_en = 1'b1; poke_addr = a; poke_data = d; settle();
      next(); poke_en = 1'b0; settle();
   endtask

   task automatic wait_cpu_done(input string tag);
      cpu_exp_t e;
      int n;
      n = 0;
      while (n < 20) begin
         next(); cpu_req = 1'b0; settle();
         n++;
         if (cpu_done) break;
      end
      checks++;
      if (cpu_done !== 1'b1) begin
         errors++;
         $display("FAIL %s cpu_done: got %b want 1 within 20 cycles", tag, cpu_done);
         cpu_q.delete();
      end else begin
         e = cpu_q.pop_front();
         if (!e.we) begin
            checks++;
            if (cpu_rdata !== e.data) begin
               errors++;
               $display("FAIL %s cpu_rdata: got %h want %h", tag, cpu_rdata, e.data);
            end
         end
      end
   endtask

   task automatic cpu_access(input logic we, input logic [10:0] a, input logic [15:0] d,
                             input logic [15:0] rexp, input string tag);
      int n;
      n = 0;
      next(); cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; settle();
      while (!cpu_rdy && n < 20) begin
         next(); settle(); n++;
      end
      checks++;
      if (cpu_rdy !== 1'b1) begin
         errors++;
         $display("FAIL %s cpu_rdy: got %b want 1 within 20 cycles", tag, cpu_rdy);
      end
      cpu_q.push_back(cpu_exp_t'{we: we, data: rexp});
      wait_cpu_done(tag);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) begin next(); settle(); end
      checks++; if (cpu_rdy !== 1'b1)   begin errors++; $display("FAIL reset cpu_rdy: got %b want 1", cpu_rdy); end
      checks++; if (cpu_done !== 1'b0)  begin errors++; $display("FAIL reset cpu_done: got %b want 0", cpu_done); end
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset fill_busy: got %b want 0", fill_busy); end
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset fill_done: got %b want 0", fill_done); end
      checks++; if (sram_we !== 1'b0)   begin errors++; $display("FAIL reset sram_we: got %b want 0", sram_we); end
      next(); reset = 1'b0; settle();
      checks++;
      if (sram_addr !== 11'h000 || sram_we !== 1'b0) begin
         errors++;
         $display("FAIL idle sram: got addr %h we %b want addr 000 we 0", sram_addr, sram_we);
      end
   endtask

   task automatic test_display();
      logic [10:0] a_tbl [4];
      logic [15:0] e;
      int          bad_we;
      a_tbl = '{11'h123, 11'h000, 11'h7FF, 11'h456};
      bad_we = 0;
      init_mem(16'hC000);
      poke(11'h123, 16'hA5C3);
      for (int i = 0; i <= 4; i++) begin
         next();
         disp_req  = (i < 4);
         disp_addr = (i < 4) ? a_tbl[i] : 11'h000;
         settle();
         if (i > 0) begin
            e = disp_q.pop_front();
            checks++;
            if (disp_rdata !== e) begin
               errors++;
               $display("FAIL display rdata[%0d]: got %h want %h", i - 1, disp_rdata, e);
            end
         end
         if (i < 4) begin
            checks++;
            if (sram_addr !== a_tbl[i]) begin
               errors++;
               $display("FAIL display sram_addr[%0d]: got %h want %h", i, sram_addr, a_tbl[i]);
            end
            if (sram_we) bad_we++;
            disp_q.push_back(a_tbl[i] == 11'h123 ? 16'hA5C3 : bg(int'(a_tbl[i])));
         end
      end
      checks++;
      if (bad_we != 0) begin errors++; $display("FAIL display sram_we: got %0d writes want 0", bad_we); end
   endtask

   task automatic test_cpu_write_read();
      cpu_exp_t e;
      next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h045; cpu_wdata = 16'h1234; settle();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL wr accept cpu_rdy: got %b want 1", cpu_rdy); end
      cpu_q.push_back(cpu_exp_t'{we: 1'b1, data: 16'h0000});
      next(); cpu_req = 1'b0; settle();
      checks++;
      if (sram_we !== 1'b1 || sram_addr !== 11'h045 || sram_wdata !== 16'h1234 || cpu_rdy !== 1'b0) begin
         errors++;
         $display("FAIL wr issue: got we %b addr %h data %h rdy %b want 1 045 1234 0",
                  sram_we, sram_addr, sram_wdata, cpu_rdy);
      end
      next(); settle();
      checks++;
      if (cpu_done !== 1'b1) begin
         errors++; $display("FAIL wr cpu_done: got %b want 1", cpu_done);
      end else begin
         e = cpu_q.pop_front();
         checks++;
         if (e.we !== 1'b1) begin errors++; $display("FAIL wr scoreboard kind: got %b want 1", e.we); end
      end
      cpu_access(1'b0, 11'h045, 16'h0000, 16'h1234, "rd 045");
   endtask

   task automatic test_collision();
      cpu_exp_t e;
      int       bad;
      bad = 0;
      next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 16'h0BAD; disp_req = 1'b0; settle();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL coll accept cpu_rdy: got %b want 1", cpu_rdy); end
      cpu_q.push_back(cpu_exp_t'{we: 1'b1, data: 16'h0000});
      for (int k = 1; k <= 3; k++) begin
         next(); cpu_req = 1'b0; disp_req = 1'b1; disp_addr = 11'h200; settle();
         if (cpu_rdy !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 11'h200) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL coll blocked: got %0d bad cycles want 0", bad); end
      next(); disp_req = 1'b0; settle();
      checks++;
      if (sram_we !== 1'b1 || sram_addr !== 11'h010 || cpu_rdy !== 1'b0 || cpu_done !== 1'b0) begin
         errors++;
         $display("FAIL coll issue N+4: got we %b addr %h rdy %b done %b want 1 010 0 0",
                  sram_we, sram_addr, cpu_rdy, cpu_done);
      end
      next(); settle();
      checks++;
      if (cpu_done !== 1'b1 || cpu_rdy !== 1'b1) begin
         errors++; $display("FAIL coll done N+5: got done %b rdy %b want 1 1", cpu_done, cpu_rdy);
      end else begin
         e = cpu_q.pop_front();
      end
      next(); settle();
      checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL coll done pulse N+6: got %b want 0", cpu_done); end
      cpu_access(1'b0, 11'h010, 16'h0000, 16'h0BAD, "rd 010");
   endtask

   task automatic test_back_to_back();
      int acc [4];
      int idx;
      int done_n;
      idx = 0;
      done_n = 0;
      for (int n = 0; n < 30 && done_n < 4; n++) begin
         next();
         cpu_req   = (idx < 4);
         cpu_we    = 1'b1;
         cpu_addr  = 11'(32'h300 + idx);
         cpu_wdata = 16'(32'h5000 + idx);
         settle();
         if (cpu_done) begin void'(cpu_q.pop_front()); done_n++; end
         if (cpu_req && cpu_rdy) begin
            acc[idx] = n;
            cpu_q.push_back(cpu_exp_t'{we: 1'b1, data: 16'h0000});
            idx++;
         end
      end
      next(); cpu_req = 1'b0; settle();
      checks++;
      if (idx != 4 || done_n != 4 || acc[3] - acc[0] != 6) begin
         errors++;
         $display("FAIL b2b rate: got %0d accepts %0d dones span %0d want 4 4 6", idx, done_n, acc[3] - acc[0]);
      end
      for (int i = 0; i < 4; i++)
         cpu_access(1'b0, 11'(32'h300 + i), 16'h0000, 16'(32'h5000 + i), "rd b2b");
   endtask

   task automatic test_fill();
      int busy_n, addr_err, done_n, bad;
      busy_n = 0; addr_err = 0; done_n = 0; bad = 0;
      init_mem(16'hC000);
      next(); fill_start = 1'b1; fill_value = 16'h0720; settle();
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL fill pre-start busy: got %b want 0", fill_busy); end
      for (int n = 0; n < 3000; n++) begin
         next();
         fill_start = (n == 500);
         if (n == 500) fill_value = 16'h1111;
         settle();
         if (fill_done) done_n++;
         if (fill_busy) begin
            if (sram_we !== 1'b1 || sram_addr !== 11'(busy_n) || sram_wdata !== 16'h0720) addr_err++;
            busy_n++;
         end
         if (done_n >= 1 && !fill_done) break;
      end
      checks++; if (busy_n != 2048)  begin errors++; $display("FAIL fill busy cycles: got %0d want 2048", busy_n); end
      checks++; if (addr_err != 0)   begin errors++; $display("FAIL fill write sequence: got %0d bad want 0", addr_err); end
      checks++; if (done_n != 1)     begin errors++; $display("FAIL fill_done pulses: got %0d want 1", done_n); end
      for (int i = 0; i < 2048; i++) if (mem[i] !== 16'h0720) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL fill contents: got %0d bad words want 0", bad); end
   endtask

   task automatic test_fill_load();
      int collide, fill_w, cpu_iss, fill7ff, done_n, multi;
      logic [15:0] exp7ff;
      collide = 0; fill_w = 0; cpu_iss = -1; fill7ff = -1; done_n = 0; multi = 0;
      for (int i = 0; i < 2048; i++) wcnt[i] = 0;
      init_mem(16'hC000);
      next(); fill_start = 1'b1; fill_value = 16'h0720; settle();
      for (int n = 0; n < 6000; n++) begin
         next();
         fill_start = 1'b0;
         disp_req   = (n % 16 == 0);
         disp_addr  = 11'(n * 37);
         cpu_req    = (n == 1000);
         cpu_we     = 1'b1;
         cpu_addr   = 11'h7FF;
         cpu_wdata  = 16'hBEEF;
         settle();
         if (cpu_req && cpu_rdy) cpu_q.push_back(cpu_exp_t'{we: 1'b1, data: 16'h0000});
         if (sram_we && disp_req) collide++;
         if (sram_we && sram_wdata === 16'h0720) begin
            wcnt[sram_addr]++;
            fill_w++;
            if (sram_addr == 11'h7FF) fill7ff = n;
         end
         if (sram_we && sram_wdata === 16'hBEEF) cpu_iss = n;
         if (cpu_done) begin void'(cpu_q.pop_front()); done_n++; end
         if (n > 1000 && !fill_busy && cpu_q.size() == 0) break;
      end
      next(); disp_req = 1'b0; cpu_req = 1'b0; settle();
      for (int i = 0; i < 2048; i++) if (wcnt[i] != 1) multi++;
      exp7ff = (cpu_iss > fill7ff) ? 16'hBEEF : 16'h0720;
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL load fill_busy: got %b want 0", fill_busy); end
      checks++; if (collide != 0) begin errors++; $display("FAIL load display collisions: got %0d want 0", collide); end
      checks++; if (fill_w != 2048) begin errors++; $display("FAIL load fill writes: got %0d want 2048", fill_w); end
      checks++; if (multi != 0) begin errors++; $display("FAIL load per-address writes: got %0d not-once want 0", multi); end
      checks++; if (done_n != 1 || cpu_iss < 0) begin errors++; $display("FAIL load cpu write: got %0d dones issue %0d want 1 and issued", done_n, cpu_iss); end
      checks++; if (mem[2047] !== exp7ff) begin errors++; $display("FAIL load word 7FF: got %h want %h", mem[2047], exp7ff); end
   endtask

   task automatic test_reset_mid_fill();
      int found, stray, bad;
      found = 0; stray = 0; bad = 0;
      init_mem(16'hC000);
      next(); fill_start = 1'b1; fill_value = 16'h3C3C; settle();
      for (int n = 0; n < 300; n++) begin
         next(); fill_start = 1'b0; settle();
         if (sram_we && sram_addr == 11'd100) begin found = 1; break; end
      end
      checks++; if (found != 1) begin errors++; $display("FAIL midfill reach 100: got %0d want 1", found); end
      reset = 1'b1;
      #1;
      checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL midfill we under reset: got %b want 0", sram_we); end
      next(); reset = 1'b0; settle();
      checks++;
      if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
         errors++; $display("FAIL midfill abort: got busy %b done %b want 0 0", fill_busy, fill_done);
      end
      // A pending CPU write held off by the display, then reset: it must vanish.
      next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h600; cpu_wdata = 16'hFFFF; settle();
      next(); cpu_req = 1'b0; disp_req = 1'b1; disp_addr = 11'h001; reset = 1'b1; settle();
      next(); disp_req = 1'b0; reset = 1'b0; settle();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL drop cpu_rdy: got %b want 1", cpu_rdy); end
      for (int n = 0; n < 6; n++) begin
         next(); settle();
         if (cpu_done || fill_done || sram_we) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL post-reset activity: got %0d cycles want 0", stray); end
      for (int i = 0; i < 2048; i++) begin
         if (i < 100 && mem[i] !== 16'h3C3C) bad++;
         if (i >= 100 && mem[i] !== bg(i)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midfill contents: got %0d bad words want 0", bad); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      disp_req = 1'b0; disp_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      fill_start = 1'b0; fill_value = '0;
      init_en = 1'b0; init_base = '0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;

      test_reset();
      test_display();
      test_cpu_write_read();
      test_collision();
      test_back_to_back();
      test_fill();
      test_fill_load();
      test_reset_mid_fill();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single synchronous-read VRAM port (2048 x DW) and shares it between three requesters: the character display fetch, a CPU/bus master, and a built-in screen-fill engine.
- The display fetch has absolute priority and zero added latency, so character fetch timing is unchanged.
- The CPU gets a one-entry buffered valid/ready port.
- The fill engine clears or fills the whole VRAM using only idle cycles.

Parameters:
- AW, 11, VRAM address width (64 cols x 32 rows).
- DW, 16, VRAM data width (8 for mono, 16 for RGB attribute+char).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display fetch this cycle (the display engine's load strobe)
- disp_addr  in  AW  display fetch address, valid with disp_req
- disp_rdata  out  DW  display read data, valid the cycle after disp_req
- cpu_req  in  1  CPU request valid
- cpu_rdy  out  1  CPU request accepted when cpu_req & cpu_rdy
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_done  out  1  one-cycle pulse: CPU access completed
- cpu_rdata  out  DW  read data, valid when cpu_done follows a read
- fill_start  in  1  start whole-VRAM fill
- fill_value  in  DW  fill word, sampled on an accepted fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- sram_addr  out  AW  VRAM address (combinational mux)
- sram_we  out  1  VRAM write enable
- sram_wdata  out  DW  VRAM write data
- sram_rdata  in  DW  VRAM read data, one cycle after the address

Behaviour:
- Reset values: pending empty, fill state IDLE, fill counter 0, cpu_rdy=1, cpu_done=0, fill_busy=0, fill_done=0, sram_we=0.
- Port grant, evaluated each cycle with priority disp_req > CPU pending > FILL:
  - disp_req: sram_addr=disp_addr, sram_we=0.
  - CPU pending: sram_addr, we, wdata taken from the pending register.
  - FILL: sram_addr=fill_cnt, sram_we=1, sram_wdata=fill latch.
  - Otherwise: sram_we=0, sram_addr=0.
- The grant mux is purely combinational, so display address-to-data latency is exactly 1 cycle.
- disp_rdata = sram_rdata, unregistered passthrough. It is meaningful only the cycle after disp_req.
- CPU port:
  - cpu_rdy = !pending_valid.
  - An accepted request is latched into pending (addr, we, wdata) at the clock edge.
  - It issues no earlier than the next cycle, on the first cycle without disp_req, then pending clears.
  - cpu_rdy is high again the cycle after issue; back-to-back issue rate is one access per 2 cycles.
  - cpu_done pulses exactly 1 cycle after issue. For a read, cpu_rdata = sram_rdata in that cycle.
- Fill FSM:
  - IDLE: fill_start=1 → FILL, fill_cnt=0, latch fill_value, fill_busy=1.
  - FILL: each granted cycle writes fill_cnt, then fill_cnt++.
  - FILL, write of address 2^AW-1 granted → IDLE, fill_busy=0 and fill_done=1 on the next cycle.
  - fill_start while busy is ignored; fill_value is not re-sampled.
- Simultaneous events:
  - A CPU write and a fill to the same address in later cycles: the final value is whichever write issues last. No ordering guarantee is given to software beyond that.
  - cpu_req and fill_start in the same cycle: both accepted.
- Reset mid-fill: abort immediately. No fill_done, and the partial fill remains in VRAM.
- Reset with a CPU request pending: the request is dropped and no cpu_done is generated.
- Starvation: CPU and fill progress is guaranteed only because the display fetches at most once per 16 cycles. The arbiter has no fairness counter.

Decomposition:
- Package vram_pkg holds VRAM_AW=11, VRAM_DW=16, and the fill state enum {FILL_IDLE, FILL_RUN}.
- One sub-module is natural: vram_fill_seq, containing the fill FSM, counter, value latch, done pulse and a grant input. The arbiter instantiates it and owns the mux plus the CPU pending stage.

Test Plan:
- Display only: disp_req=1, disp_addr=0x123, VRAM[0x123]=0xA5C3 → sram_addr=0x123 the same cycle, disp_rdata=0xA5C3 the next cycle, sram_we never 1.
- CPU write then read: write 0x045 ← 0x1234, then read 0x045 with no disp_req → sram_we=1 on the cycle after acceptance, cpu_done pulses; the read's cpu_done cycle shows cpu_rdata=0x1234.
- Collision: cpu_req write 0x010 accepted in cycle N, disp_req held high cycles N+1..N+3 → CPU write issues in N+4, cpu_done in N+5, cpu_rdy=0 during N+1..N+4.
- Fill: fill_start with fill_value=0x0720, no other traffic → exactly 2048 writes at addresses 0..2047, fill_busy high for 2048 cycles, fill_done pulse once; all VRAM words = 0x0720.
- Fill under load:
  - Stimulus: fill running while disp_req asserts every 16th cycle and CPU writes 0x7FF ← 0xBEEF mid-fill.
  - Required: fill never writes on display cycles, every address is written once, and 0x7FF ends as 0xBEEF if the CPU write issued after the fill passed 0x7FF, otherwise 0x0720.
- Reset mid-fill at fill_cnt=100 → next cycle fill_busy=0, no fill_done; VRAM[0..99]=fill value, the rest untouched.
